// File: rtl/vergoto_nested_pkg.sv
// ============================================================================
// Module   : vergoto_nested_pkg
// Brief    : Shared types, addresses and helpers for the nested branch/exception unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vergoto_nested_pkg;

    localparam logic [31:0] IRQ_ADDRESS  = 32'h0000_0200;
    localparam logic [31:0] TRAP_ADDRESS = 32'h0000_0180;

    // Rank must hold NUM_IRQ+1 for the largest configuration (16 lines).
    localparam int c_rank_w  = 5;
    localparam int c_idx_w   = 4;
    localparam int c_cause_w = 5;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6
    } branch_t;

    typedef struct packed {
        logic    is_jump;
        logic    is_mret;
        logic    is_trap;
        branch_t branch;
    } instruction_t;

    typedef struct packed {
        logic [31:0]        mepc;
        logic               is_irq;
        logic [c_idx_w-1:0] idx;
    } exc_entry_t;

    function automatic logic vercompare(branch_t br, logic [31:0] a, logic [31:0] b);
        logic r;
        case (br)
            BR_EQ:   r = (a == b);
            BR_NE:   r = (a != b);
            BR_LT:   r = ($signed(a) < $signed(b));
            BR_GE:   r = ($signed(a) >= $signed(b));
            BR_LTU:  r = (a < b);
            BR_GEU:  r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [c_rank_w-1:0] entry_rank(exc_entry_t e);
        return e.is_irq ? (c_rank_w'(e.idx) + c_rank_w'(1)) : '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vergoto_stack.sv
// ============================================================================
// Module   : vergoto_stack
// Brief    : DEPTH-entry LIFO of exception entries with pop+push in one cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vergoto_stack
    import vergoto_nested_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  exc_entry_t                 push_data,
    output exc_entry_t                 top,
    output exc_entry_t                 below,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_cnt_w = $clog2(DEPTH+1);

    exc_entry_t         r_mem [DEPTH];
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;
    logic [c_cnt_w-1:0] w_wr_ptr;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    // A simultaneous pop+push overwrites the old top slot in place.
    assign w_wr_ptr  = w_do_pop ? (r_count - c_cnt_w'(1)) : r_count;

    always_comb begin
        top   = '0;
        below = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i + 1 == int'(r_count)) top   = r_mem[i];
            if (i + 2 == int'(r_count)) below = r_mem[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_count <= r_count + c_cnt_w'(1);
        end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(w_wr_ptr)) r_mem[i] <= push_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vergoto_nested.sv
// ============================================================================
// Module   : vergoto_nested
// Brief    : Next-PC unit with nested traps/IRQs, per-line mask and MRET tail-chain.
//            Define VERGOTO_VECTORED_EN for per-line IRQ vectors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vergoto_nested
    import vergoto_nested_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_IRQ-1:0]         irq,
    input  logic                       mask_we,
    input  logic [NUM_IRQ-1:0]         mask_wdata,
    input  instruction_t               instr,
    input  logic [31:0]                xs1,
    input  logic [31:0]                xs2,
    input  logic [31:0]                address,
    input  logic [31:0]                pc_incr,
    output logic [31:0]                pc_next,
    output logic                       will_jump,
    output logic [NUM_IRQ-1:0]         irq_ack,
    output logic [c_cause_w-1:0]       mcause,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       stack_err
);

    localparam logic [c_rank_w-1:0] c_idle_rank = c_rank_w'(NUM_IRQ + 1);

    logic [NUM_IRQ-1:0]         r_mask;
    logic                       r_err;
    exc_entry_t                 w_top;
    exc_entry_t                 w_below;
    exc_entry_t                 w_push_data;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic [$clog2(DEPTH+1)-1:0] w_count;
    logic                       w_taken;
    logic                       w_mret_ok;
    logic                       w_mret_empty;
    logic                       w_room;
    logic                       w_has_req;
    logic                       w_accept;
    logic                       w_trap_push;
    logic [NUM_IRQ-1:0]         w_pending;
    logic [c_idx_w-1:0]         w_sel;
    logic [c_rank_w-1:0]        w_cur_rank;
    logic [c_rank_w-1:0]        w_below_rank;
    logic [c_rank_w-1:0]        w_base_rank;
    logic [c_rank_w-1:0]        w_sel_rank;
    logic [31:0]                w_pc_target;
    logic [31:0]                w_irq_vector;

    assign w_taken      = vercompare(instr.branch, xs1, xs2);
    assign w_mret_ok    = instr.is_mret & ~w_empty;
    assign w_mret_empty = instr.is_mret & w_empty;

    assign w_cur_rank   = w_empty ? c_idle_rank : entry_rank(w_top);
    assign w_below_rank = (int'(w_count) >= 2) ? entry_rank(w_below) : c_idle_rank;
    // An MRET retires the top entry, so the competing rank is the one beneath it.
    assign w_base_rank  = instr.is_mret ? w_below_rank : w_cur_rank;

    assign w_pending = irq & r_mask;

    always_comb begin
        w_has_req = 1'b0;
        w_sel     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_has_req = 1'b1;
                w_sel     = c_idx_w'(i);
            end
        end
    end

    assign w_sel_rank  = c_rank_w'(w_sel) + c_rank_w'(1);
    assign w_room      = ~w_full | w_mret_ok;
    assign w_accept    = enable & w_has_req & (w_sel_rank < w_base_rank) & w_room & ~instr.is_trap;
    assign w_trap_push = enable & instr.is_trap & w_room;
    assign w_push      = w_accept | w_trap_push;
    assign w_pop       = enable & w_mret_ok;

    always_comb begin
        w_pc_target = pc_incr;
        if (instr.is_mret) begin
            w_pc_target = w_empty ? pc_incr : w_top.mepc;
        end else if (instr.is_jump || w_taken) begin
            w_pc_target = {address[31:2], 2'b00};
        end
    end

`ifdef VERGOTO_VECTORED_EN
    assign w_irq_vector = IRQ_ADDRESS + (32'(w_sel) << 2);
`else
    assign w_irq_vector = IRQ_ADDRESS;
`endif

    // On a tail-chain the target is the popped mepc, which becomes the new entry's mepc.
    assign w_push_data.mepc   = w_pc_target;
    assign w_push_data.is_irq = w_accept;
    assign w_push_data.idx    = w_accept ? w_sel : '0;

    vergoto_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_data),
        .top       (w_top),
        .below     (w_below),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign pc_next   = w_accept ? w_irq_vector :
                       instr.is_trap ? TRAP_ADDRESS : w_pc_target;
    assign will_jump = w_accept | instr.is_trap |
                       (instr.is_mret ? ~w_empty : (instr.is_jump | w_taken));
    assign irq_ack   = w_accept ? (NUM_IRQ'(1) << w_sel) : '0;
    assign mcause    = w_empty ? '0 : {w_top.is_irq, w_top.idx};
    assign level     = w_count;
    assign stack_err = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            r_err  <= 1'b0;
        end else if (enable) begin
            if (mask_we) r_mask <= mask_wdata;
            if ((instr.is_trap && !w_room) || w_mret_empty) r_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: doc/vergoto_nested.md
# vergoto_nested

Next-generation branch and exception unit for the Vermicel core. It computes the next program counter from jumps, conditional branches, traps, MRET and a parametrised vector of prioritised interrupt lines. Unlike the single-level unit, it supports nested exceptions through an MEPC/cause stack, per-line masking and MRET tail-chaining. It sits beside the program counter register in the execute stage; it does not hold the PC itself.

## Interface
- NUM_IRQ, 4: number of interrupt lines (1..16); line 0 has the highest priority.
- DEPTH, 2: exception stack depth (1..8).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  qualifies every state update.
- irq  input  NUM_IRQ  level-sensitive interrupt requests.
- mask_we  input  1  writes irq_mask when enable is high.
- mask_wdata  input  NUM_IRQ  new mask value; 1 = line enabled.
- instr  input  instruction_t  decoded fields: is_jump, is_mret, is_trap, branch condition.
- xs1, xs2  input  32  branch comparison operands.
- address  input  32  jump or branch target.
- pc_incr  input  32  sequential next PC.
- pc_next  output  32  next PC, combinational.
- will_jump  output  1  pc_next is not pc_incr by construction.
- irq_ack  output  NUM_IRQ  one-hot pulse for the line accepted this cycle.
- mcause  output  5  top-of-stack cause: bit 4 = interrupt, bits 3:0 = line index; 0 when the stack is empty.
- level  output  $clog2(DEPTH+1)  current stack occupancy.
- stack_err  output  1  sticky overflow/underflow flag.

## Operation
- The stack holds entries {mepc, is_irq, idx}. Priority rank: trap = 0, line i = i+1, idle = NUM_IRQ+1.
- cur_rank is the rank of the top entry, or idle when the stack is empty.
- pc_target:
  - is_mret: top mepc.
  - is_jump or branch taken: {address[31:2],2'b0}.
  - otherwise: pc_incr.
- Base rank is the rank of the entry below the top when is_mret is set, otherwise cur_rank.
- IRQ accept: choose the lowest i with irq[i] & mask[i]. Accept it when i+1 < base rank, the stack has room (or is_mret pops this cycle), and is_trap is clear.
- Trap handling:
  - Trap beats IRQ in the same cycle. The IRQ stays pending.
  - The trap blocks all IRQs until its MRET.
- Push: on trap or accept, push {pc_target, cause}.
  - Trap with a full stack: pc_next = TRAP_ADDRESS, no push, stack_err is set.
- MRET with accept (tail-chain): pop and push in the same cycle. Occupancy is unchanged, and the new entry's mepc is the popped mepc.
- MRET with an empty stack: pc_next = pc_incr, will_jump = 0, stack_err is set.
- pc_next priority order: accept, then trap (TRAP_ADDRESS), then pc_target.
- will_jump = is_mret | is_jump | taken | accept | is_trap, except for the empty-stack MRET case, which gives 0.
- All updates (stack, mask, stack_err) are gated by enable. When enable is low, irq_ack is forced to 0.

## Timing
- pc_next, will_jump and irq_ack are combinational from inputs and state within the same cycle.
- Stack, mask and flag update on the rising clk edge when enable is high. Outputs reflect the new state in the next cycle.
- Reset (asynchronous, any cycle, mid-nesting included) sets:
  - stack occupancy 0, irq_mask 0, stack_err 0;
  - mcause 0, level 0, irq_ack 0.
  With no instruction flags set, pc_next = pc_incr.
- A mask write and an IRQ in the same cycle: acceptance uses the old mask.

## Configuration
- VERGOTO_VECTORED_EN defined: accepted line i jumps to IRQ_ADDRESS + 4*i.
- VERGOTO_VECTORED_EN undefined: every line jumps to IRQ_ADDRESS, and software reads mcause to find the source.

## Structure
- Vermicel_pkg gains:
  - exc_entry_t (mepc, is_irq, idx);
  - rank width and cause encoding constants.
- IRQ_ADDRESS and TRAP_ADDRESS stay in Vermicel_pkg.
- Reuse Vercompare for the taken signal.
- One new sub-module, vergoto_stack: a DEPTH-entry LIFO with push, pop, simultaneous pop+push, top and below-top read ports, and full/empty flags.

## Test plan
- Mask 4'b0011, irq 4'b0010 at pc_incr 0x104:
  - pc_next = IRQ_ADDRESS+4 (vectored);
  - irq_ack 4'b0010, mcause 0x11, level 1;
  - MRET then returns to 0x104.
- Nesting: inside line 1, raise irq[0]. Expect accept and level 2. irq[2] with mask set is ignored until both MRETs complete.
- Tail-chain: inside line 1 with irq[2] pending, MRET gives pc_next = IRQ_ADDRESS+8, level stays 1, and mepc is kept.
- Trap and irq[0] in the same cycle:
  - pc_next = TRAP_ADDRESS, mcause 0x00;
  - irq[0] is accepted only after MRET.
- DEPTH=2 full, then a trap: pc_next = TRAP_ADDRESS, level stays 2, stack_err = 1. MRET at level 0 gives pc_next = pc_incr and will_jump = 0.
- Reset deasserts mid-nesting at level 2: level 0, mask 0, stack_err 0; subsequent irq is ignored until a mask write.
